shot_arbiter: RTL
=================

SHOT_ARBITER -- requirements
Module: shot_arbiter

Interface
REQ-001 SHALL have parameter N_ALIEN, default 4, number of alien fire requesters.
REQ-002 SHALL have parameter MOVE_DIV, default 250000, clock cycles per projectile step.
REQ-003 SHALL have parameter COOLDOWN, default 50000000, player re-fire lockout in cycles after the player shot ends.
REQ-004 SHALL have parameters Y_TOP 10, Y_BOTTOM 510, SHIP_Y 490, STEP 2 (pixels per step).
REQ-005 SHALL have ports: clk  in  1  system clock; reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: enable  in  1  game running; fire_player  in  1  active-high player fire request (level).
REQ-007 SHALL have ports: posX_Nave  in  11  ship left X; alien_req  in  N_ALIEN  per-alien fire request.
REQ-008 SHALL have ports: alien_x, alien_y  in  11*N_ALIEN each  packed shooter positions, index i at bits [11i+10:11i].
REQ-009 SHALL have ports: hit_alien  in  1  player shot struck an alien; hit_ship  in  1  alien shot struck the ship.
REQ-010 SHALL have outputs: posX_Municao1, posY_Municao1 (11 each), shot1_active (1): player projectile.
REQ-011 SHALL have outputs: posX_Municao2, posY_Municao2 (11 each), shot2_active (1): alien projectile.
REQ-012 SHALL have outputs: alien_grant  N_ALIEN  one-hot one-cycle grant pulse; tiro_ativo_jogador  1  high while player slot not IDLE.

Function
REQ-013 SHALL run a step divider 0..MOVE_DIV-1 only while enable=1; step pulse when count = MOVE_DIV-1, then count wraps to 0.
REQ-014 Player slot SHALL be FSM IDLE -> FLY -> COOL -> IDLE.
REQ-015 IDLE: fire_player=1 and enable=1 SHALL load X=posX_Nave+10, Y=SHIP_Y-2, enter FLY next cycle with shot1_active=1.
REQ-016 FLY: each step SHALL set Y=Y-STEP; if Y<Y_TOP+STEP on a step, SHALL enter COOL instead of decrementing (no wrap).
REQ-017 FLY: hit_alien=1 SHALL enter COOL next cycle regardless of step; hit and boundary in the same cycle SHALL produce one COOL entry.
REQ-018 COOL: shot1_active=0; SHALL count COOLDOWN cycles, then enter IDLE; fire_player during FLY/COOL SHALL be ignored, not queued.
REQ-019 Alien slot SHALL be FSM IDLE -> FLY -> IDLE with round-robin pointer ptr (reset 0).
REQ-020 IDLE: if any alien_req bit set, SHALL select first requester at or after ptr (modulo N_ALIEN), pulse alien_grant bit i one cycle, load X=alien_x[i]+10, Y=alien_y[i]+16, set ptr=(i+1) mod N_ALIEN, enter FLY.
REQ-021 FLY: each step SHALL set Y=Y+STEP; if Y+STEP>Y_BOTTOM on a step, or hit_ship=1, SHALL enter IDLE with shot2_active=0.
REQ-022 SHALL not issue a grant while the alien slot is FLY; alien_grant SHALL be all-zero except the grant cycle.
REQ-023 hit_alien/hit_ship while the matching slot is not FLY SHALL be ignored.
REQ-024 enable=0 SHALL synchronously return both slots to IDLE, clear divider, cooldown, positions and active flags; ptr SHALL be retained.
REQ-025 Positions SHALL hold their last value when the slot is not FLY except as cleared by REQ-024/reset.

Reset
REQ-026 reset=0 SHALL asynchronously clear: both FSMs to IDLE, divider and cooldown counters to 0, ptr to 0, all positions to 0, shot1_active, shot2_active, tiro_ativo_jogador, alien_grant to 0.
REQ-027 Reset asserted mid-flight or mid-cooldown SHALL abort immediately; after release, first fire is accepted without cooldown.

Structure
REQ-028 Slot-state encodings and Y_TOP/Y_BOTTOM/SHIP_Y/STEP SHALL live in shared package space_invaders_pkg.
REQ-029 Round-robin selection SHALL be sub-module rr_pick (inputs req, ptr; outputs valid, index, one-hot).

Verification (MOVE_DIV=4, COOLDOWN=20, N_ALIEN=4)
REQ-030 posX_Nave=445, fire_player pulse -> shot1_active=1, posX_Municao1=455, posY_Municao1=488, decreasing by 2 every 4 cycles.
REQ-031 Player shot at Y=11 on step -> COOL, shot1_active=0, tiro_ativo_jogador=1 for 20 cycles, then fire accepted again.
REQ-032 alien_req=4'b1111 held, hit_ship each flight -> grants in order 0001,0010,0100,1000,0001.
REQ-033 alien_req=4'b0100, alien_x[2]=300, alien_y[2]=100 -> posX_Municao2=310, posY_Municao2=116; hit_ship and Y_BOTTOM crossing same cycle -> single return to IDLE.
REQ-034 reset low during player FLY -> all outputs 0 same cycle; fire after release starts immediately.
REQ-035 enable=0 during both flights -> both active flags 0 next cycle, divider 0, ptr unchanged.

Source files
------------

// File: rtl/space_invaders_pkg.sv
// Shared slot-state encodings and playfield geometry for the projectile logic.
package space_invaders_pkg;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_FLY  = 2'd1,
    P_COOL = 2'd2
  } player_state_t;

  typedef enum logic {
    A_IDLE = 1'b0,
    A_FLY  = 1'b1
  } alien_state_t;

  localparam int DEF_Y_TOP    = 10;
  localparam int DEF_Y_BOTTOM = 510;
  localparam int DEF_SHIP_Y   = 490;
  localparam int DEF_STEP     = 2;

endpackage

// File: rtl/shot_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] index,
  output logic [N-1:0]  onehot
);

  int c;

  always_comb begin
    valid  = 1'b0;
    index  = '0;
    onehot = '0;
    c      = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!valid && req[c[PW-1:0]]) begin
        valid               = 1'b1;
        index               = c[PW-1:0];
        onehot[c[PW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shot_arbiter.sv
// Player and alien projectile slots sharing one step divider; alien fire is
// arbitrated round-robin among the requesting shooters.
module shot_arbiter
  import space_invaders_pkg::*;
#(
  parameter int N_ALIEN  = 4,
  parameter int MOVE_DIV = 250000,
  parameter int COOLDOWN = 50000000,
  parameter int Y_TOP    = DEF_Y_TOP,
  parameter int Y_BOTTOM = DEF_Y_BOTTOM,
  parameter int SHIP_Y   = DEF_SHIP_Y,
  parameter int STEP     = DEF_STEP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fire_player,
  input  logic [10:0]            posX_Nave,
  input  logic [N_ALIEN-1:0]     alien_req,
  input  logic [11*N_ALIEN-1:0]  alien_x,
  input  logic [11*N_ALIEN-1:0]  alien_y,
  input  logic                   hit_alien,
  input  logic                   hit_ship,
  output logic [10:0]            posX_Municao1,
  output logic [10:0]            posY_Municao1,
  output logic                   shot1_active,
  output logic [10:0]            posX_Municao2,
  output logic [10:0]            posY_Municao2,
  output logic                   shot2_active,
  output logic [N_ALIEN-1:0]     alien_grant,
  output logic                   tiro_ativo_jogador
);

  localparam int PW    = (N_ALIEN > 1) ? $clog2(N_ALIEN) : 1;
  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int CD_W  = $clog2(COOLDOWN + 1);

  localparam logic [11:0] TOP_LIM = 12'(Y_TOP + STEP);
  localparam logic [11:0] BOT_LIM = 12'(Y_BOTTOM);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] FIRE_Y  = 11'(SHIP_Y - 2);

  // Step divider: runs only while the game is enabled
  logic [DIV_W-1:0] div_cnt;
  logic             step;

  assign step = enable && (div_cnt == DIV_W'(MOVE_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               div_cnt <= '0;
    else if (!enable || step) div_cnt <= '0;
    else                      div_cnt <= div_cnt + 1'b1;
  end

  // Player slot
  player_state_t   p_state, p_state_nx;
  logic [10:0]     x1, y1, x1_nx, y1_nx;
  logic [CD_W-1:0] cd_cnt, cd_nx;

  always_comb begin
    p_state_nx = p_state;
    x1_nx      = x1;
    y1_nx      = y1;
    cd_nx      = cd_cnt;
    if (!enable) begin
      p_state_nx = P_IDLE;
      x1_nx      = '0;
      y1_nx      = '0;
      cd_nx      = '0;
    end else begin
      case (p_state)
        P_IDLE: begin
          if (fire_player) begin
            x1_nx      = posX_Nave + 11'd10;
            y1_nx      = FIRE_Y;
            p_state_nx = P_FLY;
          end
        end
        P_FLY: begin
          // A hit and a boundary step in the same cycle land in one COOL entry
          if (hit_alien) begin
            p_state_nx = P_COOL;
          end else if (step) begin
            if ({1'b0, y1} < TOP_LIM) p_state_nx = P_COOL;
            else                      y1_nx      = y1 - STEP_W;
          end
        end
        P_COOL: begin
          if (cd_cnt == CD_W'(COOLDOWN - 1)) begin
            cd_nx      = '0;
            p_state_nx = P_IDLE;
          end else begin
            cd_nx = cd_cnt + 1'b1;
          end
        end
        default: p_state_nx = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_state <= P_IDLE;
      x1      <= '0;
      y1      <= '0;
      cd_cnt  <= '0;
    end else begin
      p_state <= p_state_nx;
      x1      <= x1_nx;
      y1      <= y1_nx;
      cd_cnt  <= cd_nx;
    end
  end

  // Alien slot
  alien_state_t       a_state, a_state_nx;
  logic [10:0]        x2, y2, x2_nx, y2_nx;
  logic [PW-1:0]      ptr, ptr_nx;
  logic [N_ALIEN-1:0] grant, grant_nx;
  logic               pick_vld;
  logic [PW-1:0]      pick_idx;
  logic [N_ALIEN-1:0] pick_oh;
  logic [10:0]        ax [N_ALIEN];
  logic [10:0]        ay [N_ALIEN];

  for (genvar i = 0; i < N_ALIEN; i++) begin : g_unpack
    assign ax[i] = alien_x[11*i +: 11];
    assign ay[i] = alien_y[11*i +: 11];
  end

  rr_pick #(
    .N  (N_ALIEN),
    .PW (PW)
  ) u_rr_pick (
    .req    (alien_req),
    .ptr    (ptr),
    .valid  (pick_vld),
    .index  (pick_idx),
    .onehot (pick_oh)
  );

  always_comb begin
    a_state_nx = a_state;
    x2_nx      = x2;
    y2_nx      = y2;
    ptr_nx     = ptr;
    grant_nx   = '0;
    if (!enable) begin
      a_state_nx = A_IDLE;
      x2_nx      = '0;
      y2_nx      = '0;
    end else if (a_state == A_IDLE) begin
      if (pick_vld) begin
        grant_nx   = pick_oh;
        x2_nx      = ax[pick_idx] + 11'd10;
        y2_nx      = ay[pick_idx] + 11'd16;
        ptr_nx     = (pick_idx == PW'(N_ALIEN - 1)) ? '0 : pick_idx + 1'b1;
        a_state_nx = A_FLY;
      end
    end else begin
      if (hit_ship) begin
        a_state_nx = A_IDLE;
      end else if (step) begin
        if (({1'b0, y2} + {1'b0, STEP_W}) > BOT_LIM) a_state_nx = A_IDLE;
        else                                          y2_nx      = y2 + STEP_W;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_state <= A_IDLE;
      x2      <= '0;
      y2      <= '0;
      ptr     <= '0;
      grant   <= '0;
    end else begin
      a_state <= a_state_nx;
      x2      <= x2_nx;
      y2      <= y2_nx;
      ptr     <= ptr_nx;
      grant   <= grant_nx;
    end
  end

  assign posX_Municao1      = x1;
  assign posY_Municao1      = y1;
  assign shot1_active       = (p_state == P_FLY);
  assign tiro_ativo_jogador = (p_state != P_IDLE);
  assign posX_Municao2      = x2;
  assign posY_Municao2      = y2;
  assign shot2_active       = (a_state == A_FLY);
  assign alien_grant        = grant;

endmodule
